// File: rtl/aes_decrypt_controller.sv
// Sequencing FSM for the AES-128 inverse cipher: drives load, write-enable,
// op/column selects and round-key index into the existing datapath.
module aes_decrypt_controller #(
  parameter int KEYEXP_CYCLES = 12
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       AES_START,
  output logic       AES_DONE,
  output logic       BUSY,
  output logic       LOAD_MSG,
  output logic       STATE_WE,
  output logic [1:0] OP_SEL,
  output logic [3:0] ROUND_IDX,
  output logic [1:0] COL_SEL
);

  typedef enum logic [3:0] {
    IDLE, KEYEXP, INIT_ARK, ISR, ISB, ARK, IMC, F_ISR, F_ISB, F_ARK, DONE
  } state_t;

  localparam logic [1:0] OP_ARK = 2'b00;
  localparam logic [1:0] OP_ISR = 2'b01;
  localparam logic [1:0] OP_ISB = 2'b10;
  localparam logic [1:0] OP_IMC = 2'b11;
  localparam logic [7:0] KEYEXP_LAST = 8'(KEYEXP_CYCLES - 1);

  state_t     state, state_nxt;
  logic [7:0] key_cnt, key_cnt_nxt;
  logic [3:0] round_cnt, round_cnt_nxt;
  logic [1:0] col_cnt, col_cnt_nxt;
  logic       busy;
  logic       write_raw;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      key_cnt   <= '0;
      round_cnt <= '0;
      col_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      key_cnt   <= key_cnt_nxt;
      round_cnt <= round_cnt_nxt;
      col_cnt   <= col_cnt_nxt;
    end
  end

  assign busy = (state != IDLE) && (state != DONE);

  always_comb begin
    state_nxt     = state;
    key_cnt_nxt   = key_cnt;
    round_cnt_nxt = round_cnt;
    col_cnt_nxt   = col_cnt;
    case (state)
      IDLE: begin
        if (AES_START) begin
          state_nxt   = KEYEXP;
          key_cnt_nxt = '0;
        end
      end
      KEYEXP: begin
        if (key_cnt == KEYEXP_LAST) begin
          state_nxt   = INIT_ARK;
          key_cnt_nxt = '0;
        end else begin
          key_cnt_nxt = key_cnt + 8'd1;
        end
      end
      INIT_ARK: begin
        round_cnt_nxt = 4'd9;
        state_nxt     = ISR;
      end
      ISR: state_nxt = ISB;
      ISB: state_nxt = ARK;
      ARK: begin
        col_cnt_nxt = '0;
        state_nxt   = IMC;
      end
      IMC: begin
        col_cnt_nxt = col_cnt + 2'd1;
        // Last column closes the round; round 1 hands over to the final round.
        if (col_cnt == 2'd3) begin
          round_cnt_nxt = round_cnt - 4'd1;
          state_nxt     = (round_cnt > 4'd1) ? ISR : F_ISR;
        end
      end
      F_ISR: state_nxt = F_ISB;
      F_ISB: state_nxt = F_ARK;
      F_ARK: state_nxt = DONE;
      DONE: begin
        if (!AES_START) begin
          state_nxt     = IDLE;
          round_cnt_nxt = '0;
          col_cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (busy && !AES_START) begin
      state_nxt     = IDLE;
      key_cnt_nxt   = '0;
      round_cnt_nxt = '0;
      col_cnt_nxt   = '0;
    end
  end

  always_comb begin
    write_raw = 1'b0;
    OP_SEL    = OP_ARK;
    ROUND_IDX = '0;
    COL_SEL   = '0;
    case (state)
      INIT_ARK: begin write_raw = 1'b1; OP_SEL = OP_ARK; ROUND_IDX = 4'd10;     end
      ISR:      begin write_raw = 1'b1; OP_SEL = OP_ISR;                        end
      ISB:      begin write_raw = 1'b1; OP_SEL = OP_ISB;                        end
      ARK:      begin write_raw = 1'b1; OP_SEL = OP_ARK; ROUND_IDX = round_cnt; end
      IMC:      begin write_raw = 1'b1; OP_SEL = OP_IMC; COL_SEL = col_cnt;     end
      F_ISR:    begin write_raw = 1'b1; OP_SEL = OP_ISR;                        end
      F_ISB:    begin write_raw = 1'b1; OP_SEL = OP_ISB;                        end
      F_ARK:    begin write_raw = 1'b1; OP_SEL = OP_ARK;                        end
      default:  ;
    endcase
  end

  // Start gating keeps an abort cycle from touching the state register.
  assign STATE_WE = write_raw & AES_START;
  assign LOAD_MSG = (state == KEYEXP) && (key_cnt == 8'd0) && AES_START;
  assign BUSY     = busy;
  assign AES_DONE = (state == DONE);

endmodule
